// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester-side command/done bundle plus the APB master bus of apb_req_arbiter.
// Latency: none; wires only.
// Backpressure: requesters hold req until done; the APB side stalls on PREADY.
// master modport = arbiter view, slave modport = environment view (requesters + APB slave).
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    // Requester command side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;

    // APB master bus
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output gnt, done, rdata, err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req, req_write, req_addr, req_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  gnt, done, rdata, err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Latency: req high in IDLE -> PSEL next cycle; min 3 cycles/transfer (SETUP, ACCESS, IDLE+done).
// Backpressure: ACCESS stretches while PREADY=0; optional ACCESS timeout under `APB_TIMEOUT_EN.
// With APB_TIMEOUT_EN undefined, ACCESS waits for PREADY indefinitely and no counter exists.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_req_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject unsupported configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDR_W-1:0]    r_paddr;
    logic [DATA_W-1:0]    r_pwdata;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    // Arbitration result for the current IDLE cycle
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_sum;
    logic                 w_any;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [NUM_REQ-1:0]   w_sel_onehot;
    logic                 w_sel_write;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_timeout;
    logic [IDX_W-1:0]     w_ptr_next;

`ifdef APB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]    r_tcnt;

    // The last permitted wait cycle is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
    assign w_timeout = !bus.PREADY && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        w_rot     = NUM_REQ'({bus.req, bus.req} >> r_ptr);
        w_any     = |bus.req;
        w_sum     = '0;
        w_sel_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
                if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
                end
                w_sel_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    // Mux the winning requester's command fields out of the packed buses.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_write  = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_write     = bus.req_write[i];
                w_sel_addr      = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata     = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The requester just served becomes lowest priority.
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

    // Transfer sequencer: IDLE -> SETUP -> ACCESS (-> IDLE with done pulse); all outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx    <= w_sel_idx;
                        r_pwrite <= w_sel_write;
                        r_paddr  <= w_sel_addr;
                        r_pwdata <= w_sel_wdata;
                        r_gnt    <= w_sel_onehot;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                end
                S_ACCESS: begin
                    if (bus.PREADY || w_timeout) begin
                        // A timed-out read leaves rdata alone and always reports an error.
                        if (bus.PREADY && !r_pwrite) begin
                            r_rdata <= bus.PRDATA;
                        end
                        r_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
                        r_done    <= r_gnt;
                        r_ptr     <= w_ptr_next;
                        r_gnt     <= '0;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.rdata   = r_rdata;
    assign bus.err     = r_err;
    assign bus.PSEL    = r_psel;
    assign bus.PENABLE = r_penable;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PADDR   = r_paddr;
    assign bus.PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: vector table + scoreboard bench for apb_req_arbiter.
// Latency: checks PSEL one cycle after req, ACCESS length, done spacing.
// Backpressure: a wait-state APB slave model stretches ACCESS (or stalls it for timeout/reset cases).
module tb_apb_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TO_CYC  = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        bit          slverr;
    } vec_t;

    typedef struct {
        int          idx;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          acc_len;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] model_rdata = '0;

    // Slave model controls
    int          slv_waits  = 0;
    logic [31:0] slv_prdata = '0;
    bit          slv_err    = 1'b0;
    bit          slv_stuck  = 1'b0;
    int          slv_cnt    = 0;

    // Monitor state for the transfer currently on the bus
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic               m_write;
    logic [NUM_REQ-1:0] m_gnt;
    int                 m_acc      = 0;
    bit                 m_unstable = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge PCLK) cyc++;

    // APB slave: ready after slv_waits ACCESS cycles unless stalled.
    always @(negedge PCLK) begin
        if (bus.PSEL && bus.PENABLE) begin
            if (!slv_stuck && slv_cnt >= slv_waits) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = slv_prdata;
                bus.PSLVERR = slv_err;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 32'h0BAD_0BAD;
                bus.PSLVERR = 1'b0;
            end
            slv_cnt++;
        end else begin
            bus.PREADY  = 1'b0;
            bus.PRDATA  = 32'h0BAD_0BAD;
            bus.PSLVERR = 1'b0;
            slv_cnt     = 0;
        end
    end

    // Bus monitor and scoreboard comparison on each done pulse.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET) begin
            if (bus.PSEL && !bus.PENABLE) begin
                m_addr     = bus.PADDR;
                m_wdata    = bus.PWDATA;
                m_write    = bus.PWRITE;
                m_gnt      = bus.gnt;
                m_acc      = 0;
                m_unstable = 1'b0;
            end else if (bus.PSEL && bus.PENABLE) begin
                m_acc++;
                if (bus.PADDR !== m_addr || bus.PWRITE !== m_write ||
                    bus.PWDATA !== m_wdata || bus.gnt !== m_gnt)
                    m_unstable = 1'b1;
            end
            if (bus.done != '0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=0x%0h, expected no done", bus.done);
                end else begin
                    e = sb.pop_front();
                    check("done_onehot", bus.done, 64'(1) << e.idx);
                    check("gnt_onehot", m_gnt, 64'(1) << e.idx);
                    check("rdata", bus.rdata, e.rdata);
                    check("err", bus.err, e.err);
                    check("paddr", m_addr, e.addr);
                    check("pwrite", m_write, e.write);
                    if (e.write) check("pwdata", m_wdata, e.wdata);
                    check("access_len", m_acc, e.acc_len);
                    check("cmd_stable", m_unstable, 0);
                    check("psel_low_at_done", {bus.PSEL, bus.PENABLE}, 2'b00);
                end
            end
        end
    end

    task automatic set_cmd(input int idx, input bit write, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_write[idx]                 = write;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = addr;
        bus.req_wdata[idx*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic expect_xfer(input int idx, input bit write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] prdata,
                               input bit err, input int acc_len, input bit timed_out);
        exp_t e;
        if (!write && !timed_out) model_rdata = prdata;
        e = '{idx, write, addr, wdata, model_rdata, err, acc_len};
        sb.push_back(e);
    endtask

    task automatic wait_done(input int idx, input int budget);
        int n = 0;
        while (!bus.done[idx] && n < budget) begin
            @(posedge PCLK); #1;
            n++;
        end
        check("done_seen", bus.done[idx], 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        slv_waits  = v.waits;
        slv_prdata = v.prdata;
        slv_err    = v.slverr;
        slv_stuck  = 1'b0;
        set_cmd(v.idx, v.write, v.addr, v.wdata);
        expect_xfer(v.idx, v.write, v.addr, v.wdata, v.prdata, v.slverr, v.waits + 1, 1'b0);
        bus.req[v.idx] = 1'b1;
        @(posedge PCLK); #1;
        check("setup_latency", {bus.PSEL, bus.PENABLE}, 2'b10);
        wait_done(v.idx, 40);
        bus.req[v.idx] = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        int dcyc[4];
        int nd;

        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_0110, 32'h0000_0000, 3, 32'hCAFE_BABE, 1'b0};
        vecs[2] = '{0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'h2222_2222, 1'b1};
        vecs[3] = '{1, 1'b1, 32'h0000_0024, 32'h8765_4321, 0, 32'h3333_3333, 1'b0};
        vecs[4] = '{0, 1'b0, 32'h0000_0030, 32'h0000_0000, 2, 32'hA5A5_0001, 1'b1};
        vecs[5] = '{1, 1'b0, 32'h0000_0034, 32'h0000_0000, 0, 32'h0BAD_F00D, 1'b0};

        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_psel", bus.PSEL, 0);
        check("reset_penable", bus.PENABLE, 0);
        check("reset_gnt", bus.gnt, 0);
        check("reset_done", bus.done, 0);
        check("reset_rdata", bus.rdata, 0);
        check("reset_err", bus.err, 0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Single transfers: write, waited read, slave error, recovery, error read, clean read
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while in ACCESS with a stalled slave
        slv_stuck = 1'b1;
        set_cmd(1, 1'b0, 32'h0000_0140, 32'h0);
        bus.req[1] = 1'b1;
        n = 0;
        while (!bus.PENABLE && n < 10) begin
            @(posedge PCLK); #1;
            n++;
        end
        check("reached_access", bus.PENABLE, 1);
        PRESET = 1'b1;
        #1;
        check("abort_psel", bus.PSEL, 0);
        check("abort_penable", bus.PENABLE, 0);
        check("abort_gnt", bus.gnt, 0);
        check("abort_done", bus.done, 0);
        check("abort_rdata", bus.rdata, 0);
        model_rdata = '0;

        // Fairness: both requesters held high straight out of reset
        slv_stuck = 1'b0;
        slv_waits = 0;
        slv_err   = 1'b0;
        set_cmd(0, 1'b1, 32'h0000_0100, 32'h1111_0000);
        set_cmd(1, 1'b1, 32'h0000_0104, 32'h2222_1111);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_xfer(0, 1'b1, 32'h0000_0100, 32'h1111_0000, '0, 1'b0, 1, 1'b0);
            else            expect_xfer(1, 1'b1, 32'h0000_0104, 32'h2222_1111, '0, 1'b0, 1, 1'b0);
        end
        bus.req = 2'b11;
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESET = 1'b0;
        nd = 0;
        n  = 0;
        while (nd < 4 && n < 60) begin
            @(posedge PCLK); #1;
            n++;
            if (bus.done != '0) begin
                dcyc[nd] = cyc;
                nd++;
            end
        end
        bus.req = '0;
        check("fair_done_count", nd, 4);
        for (int k = 1; k < 4; k++) begin
            if (k < nd) check("done_spacing", dcyc[k] - dcyc[k-1], 3);
        end
        repeat (4) @(posedge PCLK);
        #1;
        check("idle_after_fair", bus.PSEL, 0);

`ifdef APB_TIMEOUT_EN
        // Timeout: requester 0 stalls out, requester 1 is served next
        slv_stuck  = 1'b1;
        slv_waits  = 0;
        slv_prdata = 32'h7777_8888;
        set_cmd(0, 1'b0, 32'h0000_0200, 32'h0);
        set_cmd(1, 1'b0, 32'h0000_0204, 32'h0);
        expect_xfer(0, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1, TO_CYC, 1'b1);
        expect_xfer(1, 1'b0, 32'h0000_0204, 32'h0, 32'h7777_8888, 1'b0, 1, 1'b0);
        bus.req = 2'b11;
        wait_done(0, 40);
        bus.req[0] = 1'b0;
        slv_stuck  = 1'b0;
        wait_done(1, 40);
        bus.req[1] = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
